imem_arbiter: RTL and testbench

//  Shares one 16-bit read-only memory port between two requesters: port 0 (fetch) and port 1 (load).
//  The memory has fixed multi-cycle read latency. Its address must be held stable until the data settles.

---
 rtl/imem_arbiter_pkg.sv | 28 ++
 rtl/imem_arbiter_lat_timer.sv | 33 +++
 rtl/imem_arbiter.sv | 110 +++++++++++
 tb/tb_imem_arbiter.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/imem_arbiter_pkg.sv
// Shared definitions for the instruction/load memory arbiter: FSM encoding,
// requester indices and the tie-break helper.
package imem_arb_pkg;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t IDLE = 2'd0;
    localparam arb_state_t WAIT = 2'd1;
    localparam arb_state_t RESP = 2'd2;

    localparam logic P_FETCH = 1'b0;
    localparam logic P_LOAD  = 1'b1;

    localparam int DEFAULT_LATENCY = 4;

    // One-hot grant {port1, port0}; on a tie the port that was not served last wins.
    function automatic logic [1:0] pick_winner(input logic v0, input logic v1, input logic last);
        logic [1:0] g;
        case ({v1, v0})
            2'b01:   g = 2'b01;
            2'b10:   g = 2'b10;
            2'b11:   g = (last == P_LOAD) ? 2'b01 : 2'b10;
            default: g = 2'b00;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/imem_arbiter_lat_timer.sv
// Loadable down-counter that times the memory read; done marks the final
// cycle of the hold window and the timer disarms after it.
module lat_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic       done
);

    logic [3:0] cnt_r;
    logic       armed_r;

    // Count down from load_val to zero, then disarm.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r   <= 4'd0;
            armed_r <= 1'b0;
        end else if (load) begin
            cnt_r   <= load_val;
            armed_r <= 1'b1;
        end else if (armed_r) begin
            if (cnt_r != 4'd0) begin
                cnt_r <= cnt_r - 4'd1;
            end else begin
                armed_r <= 1'b0;
            end
        end
    end

    assign done = armed_r & (cnt_r == 4'd0);

endmodule

// File: rtl/imem_arbiter.sv
// Two-port arbiter for a fixed-latency read-only memory: grants one read at a
// time, holds the address for the full latency and returns data to the owner.
module imem_arbiter
    import imem_arb_pkg::*;
#(
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int LATENCY = DEFAULT_LATENCY
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid0,
    input  logic [AW-1:0] req_addr0,
    output logic          req_ready0,
    output logic          resp_valid0,
    output logic [DW-1:0] resp_data0,
    input  logic          req_valid1,
    input  logic [AW-1:0] req_addr1,
    output logic          req_ready1,
    output logic          resp_valid1,
    output logic [DW-1:0] resp_data1,
    output logic [AW-1:0] mem_raddr,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    localparam logic [3:0] LOAD_VAL = 4'(LATENCY - 1);

    arb_state_t    state_r;
    logic [AW-1:0] mem_raddr_r;
    logic [DW-1:0] data_q_r;
    logic          last_r;
    logic          owner_r;
    logic          resp_valid0_r;
    logic          resp_valid1_r;
    logic [1:0]    grant_s;
    logic          ready0_s;
    logic          ready1_s;
    logic          accept_s;
    logic          done_s;

    // Grant decode: ready is only offered in IDLE and never while reset is held.
    always_comb begin
        grant_s = pick_winner(req_valid0, req_valid1, last_r);
        if (!rst && (state_r == IDLE)) begin
            ready0_s = grant_s[0];
            ready1_s = grant_s[1];
        end else begin
            ready0_s = 1'b0;
            ready1_s = 1'b0;
        end
    end

    assign accept_s = ready0_s | ready1_s;

    lat_timer u_lat_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (accept_s),
        .load_val (LOAD_VAL),
        .done     (done_s)
    );

    // Transaction FSM; resp_valid registers rise on the sample edge so they are
    // high exactly during the RESP cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= IDLE;
            mem_raddr_r   <= '0;
            data_q_r      <= '0;
            last_r        <= 1'b1;
            owner_r       <= P_FETCH;
            resp_valid0_r <= 1'b0;
            resp_valid1_r <= 1'b0;
        end else begin
            resp_valid0_r <= 1'b0;
            resp_valid1_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        mem_raddr_r <= ready1_s ? req_addr1 : req_addr0;
                        owner_r     <= ready1_s;
                        last_r      <= ready1_s;
                        state_r     <= WAIT;
                    end
                end
                WAIT: begin
                    if (done_s) begin
                        data_q_r      <= mem_rdata;
                        resp_valid0_r <= (owner_r == P_FETCH);
                        resp_valid1_r <= (owner_r == P_LOAD);
                        state_r       <= RESP;
                    end
                end
                RESP:    state_r <= IDLE;
                default: state_r <= IDLE;
            endcase
        end
    end

    assign req_ready0  = ready0_s;
    assign req_ready1  = ready1_s;
    assign resp_valid0 = resp_valid0_r;
    assign resp_valid1 = resp_valid1_r;
    assign resp_data0  = data_q_r;
    assign resp_data1  = data_q_r;
    assign mem_raddr   = mem_raddr_r;
    assign busy        = (state_r != IDLE);

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter: a LATENCY=4 instance for the main scenarios
// and a LATENCY=1 instance for the short-latency address-hold case.
module tb_imem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        v0, v1, rdy0, rdy1, rv0, rv1, busy;
    logic [15:0] a0, a1, rd0, rd1, raddr, rdata;
    logic        l1_v0, l1_rdy0, l1_rdy1, l1_rv0, l1_rv1, l1_busy;
    logic [15:0] l1_a0, l1_rd0, l1_rd1, l1_raddr, l1_rdata;
    logic        l1_v1 = 1'b0;
    logic [15:0] l1_a1 = 16'h0000;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_f(input logic [15:0] addr);
        if (addr == 16'h0003) return 16'hBEEF;
        return {addr[7:0], addr[15:8]} ^ 16'h5A5A;
    endfunction

    assign rdata    = mem_f(raddr);
    assign l1_rdata = mem_f(l1_raddr);

    imem_arbiter #(.AW(16), .DW(16), .LATENCY(4)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid0(v0), .req_addr0(a0), .req_ready0(rdy0), .resp_valid0(rv0), .resp_data0(rd0),
        .req_valid1(v1), .req_addr1(a1), .req_ready1(rdy1), .resp_valid1(rv1), .resp_data1(rd1),
        .mem_raddr(raddr), .mem_rdata(rdata), .busy(busy)
    );

    imem_arbiter #(.AW(16), .DW(16), .LATENCY(1)) u_dut_l1 (
        .clk(clk), .rst(rst),
        .req_valid0(l1_v0), .req_addr0(l1_a0), .req_ready0(l1_rdy0), .resp_valid0(l1_rv0), .resp_data0(l1_rd0),
        .req_valid1(l1_v1), .req_addr1(l1_a1), .req_ready1(l1_rdy1), .resp_valid1(l1_rv1), .resp_data1(l1_rd1),
        .mem_raddr(l1_raddr), .mem_rdata(l1_rdata), .busy(l1_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Test 1: reset then idle
        rst = 1'b1; v0 = 1'b1; v1 = 1'b1; a0 = 16'h0000; a1 = 16'h0000;
        l1_v0 = 1'b1; l1_a0 = 16'h0000;
        repeat (3) @(negedge clk);
        #1;
        chk("t1_rst_rdy0", 32'(rdy0), 32'd0);
        chk("t1_rst_rdy1", 32'(rdy1), 32'd0);
        chk("t1_rst_l1rdy", 32'(l1_rdy0), 32'd0);
        rst = 1'b0; v0 = 1'b0; v1 = 1'b0; l1_v0 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            chk("t1_busy", 32'(busy), 32'd0);
            chk("t1_ready", 32'({rdy1, rdy0}), 32'd0);
            chk("t1_resp", 32'({rv1, rv0}), 32'd0);
            chk("t1_raddr", 32'(raddr), 32'd0);
            chk("t1_l1_idle", 32'({l1_busy, l1_rv0, l1_raddr}), 32'd0);
        end

        // Test 2: single fetch
        @(negedge clk);
        v0 = 1'b1; a0 = 16'h0003; #1;
        chk("t2_rdy0", 32'(rdy0), 32'd1);
        chk("t2_rdy1", 32'(rdy1), 32'd0);
        @(negedge clk); #1;
        v0 = 1'b0;
        chk("t2_busy", 32'(busy), 32'd1);
        chk("t2_raddr_e1", 32'(raddr), 32'h0003);
        chk("t2_rv0_early", 32'(rv0), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("t2_raddr_hold", 32'(raddr), 32'h0003);
            chk("t2_rv0_early", 32'(rv0), 32'd0);
        end
        @(negedge clk); #1;
        chk("t2_rv0", 32'(rv0), 32'd1);
        chk("t2_rd0", 32'(rd0), 32'hBEEF);
        chk("t2_rv1", 32'(rv1), 32'd0);
        chk("t2_raddr_resp", 32'(raddr), 32'h0003);
        @(negedge clk); #1;
        chk("t2_rv0_off", 32'(rv0), 32'd0);
        chk("t2_busy_off", 32'(busy), 32'd0);

        // Test 3: continuous tie, grants alternate starting with port 0
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 24; i++) begin
            if (i == 0) begin
                v0 = 1'b1; v1 = 1'b1; a0 = 16'h0010; a1 = 16'h0020;
            end
            #1;
            chk("t3_rdy0", 32'(rdy0), 32'((i % 12) == 0));
            chk("t3_rdy1", 32'(rdy1), 32'((i % 12) == 6));
            chk("t3_rv0", 32'(rv0), 32'((i % 12) == 5));
            chk("t3_rv1", 32'(rv1), 32'((i % 12) == 11));
            if ((i % 12) == 5)  chk("t3_rd0", 32'(rd0), 32'(mem_f(16'h0010)));
            if ((i % 12) == 11) chk("t3_rd1", 32'(rd1), 32'(mem_f(16'h0020)));
            @(negedge clk);
        end
        v0 = 1'b0; v1 = 1'b0;

        // Test 4: port 1 arrives mid-WAIT while port 0 keeps requesting
        for (int i = 0; i < 19; i++) begin
            if (i == 0)  begin v0 = 1'b1; a0 = 16'h0040; end
            if (i == 2)  begin v1 = 1'b1; a1 = 16'h0080; end
            if (i == 7)  v1 = 1'b0;
            if (i == 13) v0 = 1'b0;
            #1;
            chk("t4_rdy0", 32'(rdy0), 32'(i == 0 || i == 12));
            chk("t4_rdy1", 32'(rdy1), 32'(i == 6));
            chk("t4_rv0", 32'(rv0), 32'(i == 5 || i == 17));
            chk("t4_rv1", 32'(rv1), 32'(i == 11));
            if (i == 11) chk("t4_rd1", 32'(rd1), 32'(mem_f(16'h0080)));
            if (i == 17) chk("t4_rd0", 32'(rd0), 32'(mem_f(16'h0040)));
            @(negedge clk);
        end

        // Test 5: reset two cycles after accept aborts the read
        for (int i = 0; i < 18; i++) begin
            if (i == 0)  begin v0 = 1'b1; a0 = 16'h0100; end
            if (i == 1)  v0 = 1'b0;
            if (i == 2)  begin rst = 1'b1; v0 = 1'b1; v1 = 1'b1; end
            if (i == 3)  begin rst = 1'b0; v0 = 1'b0; v1 = 1'b0; end
            if (i == 11) begin v0 = 1'b1; v1 = 1'b1; a0 = 16'h0010; a1 = 16'h0020; end
            if (i == 12) begin v0 = 1'b0; v1 = 1'b0; end
            #1;
            chk("t5_rdy0", 32'(rdy0), 32'(i == 0 || i == 11));
            chk("t5_rdy1", 32'(rdy1), 32'd0);
            chk("t5_rv0", 32'(rv0), 32'(i == 16));
            chk("t5_rv1", 32'(rv1), 32'd0);
            chk("t5_busy", 32'(busy), 32'(i == 1 || (i >= 12 && i <= 16)));
            if (i == 2)  chk("t5_raddr_rst", 32'(raddr), 32'd0);
            if (i == 16) chk("t5_rd0", 32'(rd0), 32'(mem_f(16'h0010)));
            @(negedge clk);
        end

        // Test 6: address change during WAIT, on LATENCY=4 and LATENCY=1
        for (int i = 0; i < 13; i++) begin
            if (i == 0) begin
                v0 = 1'b1; a0 = 16'h0300; l1_v0 = 1'b1; l1_a0 = 16'h0300;
            end
            if (i == 1) begin
                a0 = 16'h0200; l1_v0 = 1'b0; l1_a0 = 16'h0200;
            end
            if (i == 7) v0 = 1'b0;
            #1;
            chk("t6_rdy0", 32'(rdy0), 32'(i == 0 || i == 6));
            chk("t6_rv0", 32'(rv0), 32'(i == 5 || i == 11));
            if (i >= 1) chk("t6_raddr", 32'(raddr), (i <= 6) ? 32'h0300 : 32'h0200);
            if (i == 5)  chk("t6_rd0_a", 32'(rd0), 32'(mem_f(16'h0300)));
            if (i == 11) chk("t6_rd0_b", 32'(rd0), 32'(mem_f(16'h0200)));
            chk("t6_l1_rdy0", 32'(l1_rdy0), 32'(i == 0));
            chk("t6_l1_rv0", 32'(l1_rv0), 32'(i == 2));
            chk("t6_l1_busy", 32'(l1_busy), 32'(i == 1 || i == 2));
            if (i >= 1) chk("t6_l1_raddr", 32'(l1_raddr), 32'h0300);
            if (i == 2) chk("t6_l1_rd0", 32'(l1_rd0), 32'(mem_f(16'h0300)));
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
